demux1_2_buf: RTL and testbench
===============================

Name: demux1_2_buf

Overview:
- Buffered 1-to-2 demultiplexer: the inverse of the 2:1 select mux.
- Accepts one valid/ready input stream and steers each beat to output channel A (sel=0) or B (sel=1).
- Each output channel has its own 2-entry buffer, so a stalled sink does not block traffic to the other channel once that channel has been selected.
- Used to split pipeline traffic, for example a memory response routed to the I-side or D-side consumer.

Parameters:
- LENGTH, 1, data width in bits of in_data, a_data, b_data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts input beat this cycle.
- in_data  input  LENGTH  input payload.
- sel  input  1  destination select, sampled with in_data: 0 selects A, 1 selects B.
- a_valid  output  1  channel A head valid.
- a_ready  input  1  channel A sink accepts.
- a_data  output  LENGTH  channel A head payload.
- b_valid  output  1  channel B head valid.
- b_ready  input  1  channel B sink accepts.
- b_data  output  LENGTH  channel B head payload.

Behaviour:
- Reset: when rst_n=0 at a rising edge, both buffers empty, a_valid=0, b_valid=0, a_data=0, b_data=0.
- Reset applies mid-transfer too: buffered beats are discarded and any beat offered that cycle is not accepted.
- Per channel X in {A,B}: 2-entry FIFO with count_X in 0..2 and a 1-bit write pointer and read pointer.
- Storage is registers; no combinational path from in_data to X_data.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when X_valid && X_ready.
- in_ready = (sel==0) ? (count_A<2 || a_ready) : (count_B<2 || b_ready).
  - Depends combinationally on sel, a_ready, b_ready.
  - Does not depend on in_valid.
- Push: on an input transfer, in_data is written into the selected channel's FIFO at its write pointer; that write pointer toggles.
- Pop: on an output transfer on X, X's read pointer toggles.
- count_X next value = count_X + push_X - pop_X.
  - Simultaneous push and pop on the same channel leaves count unchanged.
  - This is legal at count 0 only if X_valid was already 1, which it is not, so count 0 with a push goes to 1.
- Full channel: when count_X=2 and X_ready=1, a push to X is accepted in the same cycle (pop frees a slot). When count_X=2 and X_ready=0, in_ready=0 for sel=X.
- Outputs: X_valid = (count_X != 0); X_data = entry at X's read pointer.
- X_data holds stable while X_valid=1 and X_ready=0.
- Latency: an accepted beat is visible on X_valid/X_data at the next rising edge (1 cycle), never in the same cycle.
- Throughput: 1 beat/cycle per channel when the sink is always ready.
- Ordering:
  - Beats to the same channel are delivered in acceptance order.
  - No ordering guarantee between A and B.
- A beat is never duplicated and never dropped, and it is delivered only to the channel given by sel at acceptance.
- in_valid=0: no push regardless of sel or ready values.
- X_valid may rise without X_ready; the sink may hold X_ready high while X_valid=0 with no effect.
- Pointers wrap naturally as 1-bit toggles; no overflow is possible because pushes are gated by in_ready.

Test Plan:
- Reset: drive rst_n=0 with in_valid=1, sel=0, in_data=0x5 (LENGTH=8) for 2 cycles. Then a_valid=b_valid=0, a_data=b_data=0, and nothing is delivered after release.
- Streaming split: a_ready=b_ready=1; send 0x10,0x11,0x12,0x13 with sel=0,1,0,1, one per cycle. A receives 0x10,0x12 and B receives 0x11,0x13, each 1 cycle after acceptance; in_ready stays 1 throughout.
- Backpressure fill:
  - a_ready=0; push 0xA0,0xA1 with sel=0. in_ready drops to 0 for sel=0, and a_data holds 0xA0 stable.
  - With sel=1, 0xB0 is accepted and b_valid=1 next cycle.
- Full with simultaneous pop: count_A=2 (0xA0,0xA1), a_ready=1, push 0xA2 with sel=0. The push is accepted the same cycle, count stays 2, and A delivers 0xA0,0xA1,0xA2 in order.
- Drain to empty: from count_B=2, hold b_ready=1 with in_valid=0 for 3 cycles. B delivers 2 beats, then b_valid=0 and b_data is no longer presented as valid.
- Mid-operation reset: with count_A=2 and count_B=1, pulse rst_n=0 for 1 cycle. Both valids are 0 next cycle, and a subsequent push of 0x77 with sel=1 appears alone on B.

Source files
------------

// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready stream steered by sel into
// two independent 2-entry register FIFOs (channel A = sel 0, channel B = sel 1).

module demux1_2_buf_chan #(
  parameter int LENGTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [LENGTH-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic              accept,
  output logic [LENGTH-1:0] dout
);
  logic [1:0]             count;
  logic                   wptr, rptr;
  logic [1:0][LENGTH-1:0] mem;
  logic                   pop;

  assign pop    = valid & ready;
  assign valid  = (count != 2'd0);
  // A full buffer still takes a beat when the sink drains one the same cycle.
  assign accept = (count != 2'd2) | ready;
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      mem   <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

module demux1_2_buf #(
  parameter int LENGTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  input  logic              sel,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [LENGTH-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [LENGTH-1:0] b_data
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]             push, rdy, vld, acc;
  logic [NUM_CH-1:0][LENGTH-1:0] dq;

  assign rdy      = {b_ready, a_ready};
  assign in_ready = acc[sel];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = in_valid & in_ready & (sel == 1'(i));
    demux1_2_buf_chan #(.LENGTH(LENGTH)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push[i]),
      .din    (in_data),
      .ready  (rdy[i]),
      .valid  (vld[i]),
      .accept (acc[i]),
      .dout   (dq[i])
    );
  end

  assign a_valid = vld[0];
  assign a_data  = dq[0];
  assign b_valid = vld[1];
  assign b_data  = dq[1];
endmodule

// File: tb/tb_demux1_2_buf.sv
// Directed plus random bench for demux1_2_buf, checked against a queue model
// of the two channel buffers.

module tb_demux1_2_buf;
  localparam int LENGTH = 8;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, sel;
  logic [LENGTH-1:0] in_data, a_data, b_data;
  logic              a_valid, a_ready, b_valid, b_ready;

  int total = 0;
  int bad   = 0;

  logic [LENGTH-1:0] qa[$];
  logic [LENGTH-1:0] qb[$];
  bit a_clean, b_clean;
  bit chk_en = 1'b0;

  demux1_2_buf #(.LENGTH(LENGTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LENGTH-1:0] obs, input logic [LENGTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
  task automatic cyc(input logic r, input logic iv, input logic s, input logic [LENGTH-1:0] d,
                     input logic ar, input logic br);
    logic exp_rdy;
    @(negedge clk);
    rst_n = r; in_valid = iv; sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    exp_rdy = s ? (qb.size() < 2 || br) : (qa.size() < 2 || ar);
    if (chk_en) begin
      chk("in_ready", LENGTH'(in_ready), LENGTH'(exp_rdy));
      chk("a_valid", LENGTH'(a_valid), LENGTH'(qa.size() != 0));
      chk("b_valid", LENGTH'(b_valid), LENGTH'(qb.size() != 0));
      if (qa.size() != 0) chk("a_data", a_data, qa[0]);
      else if (a_clean)   chk("a_data_rst", a_data, '0);
      if (qb.size() != 0) chk("b_data", b_data, qb[0]);
      else if (b_clean)   chk("b_data_rst", b_data, '0);
    end
    @(posedge clk);
    if (!r) begin
      qa.delete(); qb.delete();
      a_clean = 1'b1; b_clean = 1'b1;
      chk_en  = 1'b1;
    end else begin
      if (qa.size() != 0 && ar) void'(qa.pop_front());
      if (qb.size() != 0 && br) void'(qb.pop_front());
      if (iv && exp_rdy) begin
        if (s) begin qb.push_back(d); b_clean = 1'b0; end
        else   begin qa.push_back(d); a_clean = 1'b0; end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;

    // Reset while a beat is offered; nothing may be delivered afterwards.
    cyc(0, 1, 0, 8'h05, 0, 0);
    cyc(0, 1, 0, 8'h05, 0, 0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);

    // Streaming split, alternating channels.
    cyc(1, 1, 0, 8'h10, 1, 1);
    cyc(1, 1, 1, 8'h11, 1, 1);
    cyc(1, 1, 0, 8'h12, 1, 1);
    cyc(1, 1, 1, 8'h13, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);

    // Backpressure on A, fill to full, rejected push, then B traffic.
    cyc(1, 1, 0, 8'hA0, 0, 0);
    cyc(1, 1, 0, 8'hA1, 0, 0);
    cyc(1, 1, 0, 8'hEE, 0, 0);
    cyc(1, 1, 1, 8'hB0, 0, 0);
    cyc(1, 1, 1, 8'hB1, 0, 0);

    // Full A with simultaneous pop accepts the push.
    cyc(1, 1, 0, 8'hA2, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 0);

    // Drain B to empty.
    cyc(1, 0, 1, 8'h00, 0, 1);
    cyc(1, 0, 1, 8'h00, 0, 1);
    cyc(1, 0, 1, 8'h00, 0, 1);
    cyc(1, 0, 1, 8'h00, 0, 1);

    // Mid-operation reset with A full and B holding one beat.
    cyc(1, 1, 0, 8'hC0, 0, 0);
    cyc(1, 1, 0, 8'hC1, 0, 0);
    cyc(1, 1, 1, 8'hD0, 0, 0);
    cyc(0, 1, 1, 8'hD1, 0, 0);
    cyc(1, 1, 1, 8'h77, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 79) != 0), 1'($urandom), 1'($urandom), 8'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end
    for (int n = 0; n < 4; n++) cyc(1, 0, 0, 8'h00, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
